// File: rtl/memory_round_ctrl.sv
// Round controller for the memory matrix game: latches a target board, shows it
// for a fixed time, scores one-hot guesses and tracks level across rounds.
module memory_round_ctrl #(
    parameter int unsigned CELLS       = 16,
    parameter int unsigned GUESS_W     = 4,
    parameter int unsigned SHOW_CYCLES = 100,
    parameter int unsigned LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CELLS-1:0]   board,
    input  logic [GUESS_W-1:0] guess_budget,
    input  logic               guess_valid,
    input  logic [CELLS-1:0]   guess,
    output logic               show_en,
    output logic               playing,
    output logic [CELLS-1:0]   target,
    output logic [CELLS-1:0]   found,
    output logic [GUESS_W-1:0] remaining,
    output logic               hit,
    output logic               miss,
    output logic               repeat_g,
    output logic               invalid,
    output logic               won,
    output logic               lost,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SHOW = 3'd1,
        S_PLAY = 3'd2,
        S_WIN  = 3'd3,
        S_LOSE = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   show_cnt;
    logic [CNT_W-1:0]   show_cnt_next;
    logic [CELLS-1:0]   target_next;
    logic [CELLS-1:0]   found_next;
    logic [GUESS_W-1:0] remaining_next;
    logic [LEVEL_W-1:0] level_next;
    logic               hit_next;
    logic               miss_next;
    logic               repeat_next;
    logic               invalid_next;

    // Guess classification, shared by next-state and output logic
    logic guess_onehot;
    logic guess_repeat;
    logic guess_on_target;
    logic round_open;
    logic eval_guess;
    logic hit_wins;
    logic miss_loses;

    assign guess_onehot    = (guess != '0) && ((guess & (guess - CELLS'(1))) == '0);
    assign guess_repeat    = (guess & found) != '0;
    assign guess_on_target = (guess & target) != '0;
    assign round_open      = start && ((state == S_IDLE) || (state == S_WIN) || (state == S_LOSE));
    // An empty target wins immediately, so guesses are only scored otherwise
    assign eval_guess      = (state == S_PLAY) && (target != '0) && guess_valid;
    assign hit_wins        = ((found | guess) == target);
    assign miss_loses      = (remaining <= GUESS_W'(1));

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            show_cnt  <= '0;
            target    <= '0;
            found     <= '0;
            remaining <= '0;
            level     <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            repeat_g  <= 1'b0;
            invalid   <= 1'b0;
            show_en   <= 1'b0;
            playing   <= 1'b0;
            won       <= 1'b0;
            lost      <= 1'b0;
        end else begin
            state     <= state_next;
            show_cnt  <= show_cnt_next;
            target    <= target_next;
            found     <= found_next;
            remaining <= remaining_next;
            level     <= level_next;
            hit       <= hit_next;
            miss      <= miss_next;
            repeat_g  <= repeat_next;
            invalid   <= invalid_next;
            show_en   <= (state_next == S_SHOW);
            playing   <= (state_next == S_PLAY);
            won       <= (state_next == S_WIN);
            lost      <= (state_next == S_LOSE);
        end
    end

    // Next-state selection for the round sequence
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (show_cnt == '0) begin
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (target == '0) begin
                    state_next = S_WIN;
                end else if (guess_valid && guess_onehot && !guess_repeat) begin
                    if (guess_on_target) begin
                        if (hit_wins) begin
                            state_next = S_WIN;
                        end
                    end else if (miss_loses) begin
                        state_next = S_LOSE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath updates and result pulses for the coming cycle
    always_comb begin
        show_cnt_next  = show_cnt;
        target_next    = target;
        found_next     = found;
        remaining_next = remaining;
        level_next     = level;
        hit_next       = 1'b0;
        miss_next      = 1'b0;
        repeat_next    = 1'b0;
        invalid_next   = 1'b0;

        if (round_open) begin
            target_next    = board;
            found_next     = '0;
            remaining_next = (guess_budget == '0) ? GUESS_W'(1) : guess_budget;
            show_cnt_next  = CNT_W'(SHOW_CYCLES - 1);
            if (state == S_LOSE) begin
                level_next = '0;
            end
        end

        if ((state == S_SHOW) && (show_cnt != '0)) begin
            show_cnt_next = show_cnt - CNT_W'(1);
        end

        if (eval_guess) begin
            if (!guess_onehot) begin
                invalid_next = 1'b1;
            end else if (guess_repeat) begin
                repeat_next = 1'b1;
            end else if (guess_on_target) begin
                hit_next   = 1'b1;
                found_next = found | guess;
            end else begin
                miss_next = 1'b1;
                if (remaining != '0) begin
                    remaining_next = remaining - GUESS_W'(1);
                end
            end
        end

        // Level advances on entry to WIN and saturates at all-ones
        if ((state_next == S_WIN) && (state != S_WIN) && (level != '1)) begin
            level_next = level + LEVEL_W'(1);
        end
    end

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Self-checking bench for memory_round_ctrl: directed test-plan steps followed by
// random traffic, all compared against a round-level behavioural model.
module tb_memory_round_ctrl;

    localparam int unsigned SHOW_N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] board;
    logic [3:0]  guess_budget;
    logic        guess_valid;
    logic [15:0] guess;
    logic        show_en;
    logic        playing;
    logic [15:0] target;
    logic [15:0] found;
    logic [3:0]  remaining;
    logic        hit;
    logic        miss;
    logic        repeat_g;
    logic        invalid;
    logic        won;
    logic        lost;
    logic [3:0]  level;

    int errors = 0;
    int checks = 0;

    memory_round_ctrl #(
        .CELLS(16), .GUESS_W(4), .SHOW_CYCLES(SHOW_N), .LEVEL_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .board(board),
        .guess_budget(guess_budget), .guess_valid(guess_valid), .guess(guess),
        .show_en(show_en), .playing(playing), .target(target), .found(found),
        .remaining(remaining), .hit(hit), .miss(miss), .repeat_g(repeat_g),
        .invalid(invalid), .won(won), .lost(lost), .level(level)
    );

    always #5 clk = ~clk;

    // Behavioural model of the game round
    localparam int PH_IDLE = 0, PH_SHOW = 1, PH_PLAY = 2, PH_WIN = 3, PH_LOSE = 4;
    int          m_phase;
    int          m_shown;
    logic [15:0] m_tgt;
    logic [15:0] m_fnd;
    int          m_rem;
    int          m_lvl;
    logic        m_hit, m_miss, m_rep, m_inv;

    task automatic model_update(input logic r, input logic s, input logic [15:0] b,
                                input logic [3:0] bud, input logic v, input logic [15:0] g);
        m_hit = 0; m_miss = 0; m_rep = 0; m_inv = 0;
        if (!r) begin
            m_phase = PH_IDLE; m_shown = 0; m_tgt = 0; m_fnd = 0; m_rem = 0; m_lvl = 0;
        end else begin
            case (m_phase)
                PH_IDLE, PH_WIN, PH_LOSE: begin
                    if (s) begin
                        if (m_phase == PH_LOSE) m_lvl = 0;
                        m_tgt = b; m_fnd = 0; m_rem = (bud == 0) ? 1 : int'(bud);
                        m_shown = 0; m_phase = PH_SHOW;
                    end
                end
                PH_SHOW: begin
                    m_shown++;
                    if (m_shown == SHOW_N) m_phase = PH_PLAY;
                end
                PH_PLAY: begin
                    if (m_tgt == 0) begin
                        m_phase = PH_WIN;
                        if (m_lvl < 15) m_lvl++;
                    end else if (v) begin
                        if ($countones(g) != 1) m_inv = 1;
                        else if ((g & m_fnd) != 0) m_rep = 1;
                        else if ((g & m_tgt) != 0) begin
                            m_hit = 1; m_fnd = m_fnd | g;
                            if (m_fnd == m_tgt) begin
                                m_phase = PH_WIN;
                                if (m_lvl < 15) m_lvl++;
                            end
                        end else begin
                            m_miss = 1;
                            if (m_rem > 0) m_rem--;
                            if (m_rem == 0) m_phase = PH_LOSE;
                        end
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("show_en",   32'(show_en),   32'(m_phase == PH_SHOW));
        check("playing",   32'(playing),   32'(m_phase == PH_PLAY));
        check("won",       32'(won),       32'(m_phase == PH_WIN));
        check("lost",      32'(lost),      32'(m_phase == PH_LOSE));
        check("target",    32'(target),    32'(m_tgt));
        check("found",     32'(found),     32'(m_fnd));
        check("remaining", 32'(remaining), 32'(m_rem));
        check("level",     32'(level),     32'(m_lvl));
        check("pulses", {28'd0, hit, miss, repeat_g, invalid},
                        {28'd0, m_hit, m_miss, m_rep, m_inv});
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] b,
                        input logic [3:0] bud, input logic v, input logic [15:0] g);
        reset = r; start = s; board = b; guess_budget = bud; guess_valid = v; guess = g;
        @(posedge clk);
        model_update(r, s, b, bud, v, g);
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);
    endtask

    task automatic guess_step(input logic [15:0] g);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, g);
    endtask

    // Start a round and run through the display window into PLAY
    task automatic start_round(input logic [15:0] b, input logic [3:0] bud);
        step(1'b1, 1'b1, b, bud, 1'b0, 16'h0);
        repeat (SHOW_N) idle_step();
    endtask

    initial begin
        int          show_seen;
        logic        r, s, v;
        logic [15:0] b, g, tmp;
        logic [3:0]  bud;

        // Reset state
        step(1'b0, 1'b0, 16'hFFFF, 4'hF, 1'b1, 16'h0001);
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);
        check("reset_level", 32'(level), 32'd0);

        // Display window lasts exactly SHOW_N cycles
        show_seen = 0;
        step(1'b1, 1'b1, 16'h0013, 4'd3, 1'b0, 16'h0);
        show_seen += int'(show_en);
        for (int i = 0; i < int'(SHOW_N); i++) begin
            idle_step();
            show_seen += int'(show_en);
        end
        check("show_cycles", 32'(show_seen), 32'(SHOW_N));
        check("play_rem", {31'd0, playing}, 32'd1);

        // Three hits win the round
        guess_step(16'h0001);
        guess_step(16'h0002);
        guess_step(16'h0010);
        check("win_level", {27'd0, won, level}, {27'd0, 1'b1, 4'd1});
        check("win_found", 32'(found), 32'h0013);

        // Two misses lose the round
        start_round(16'h0001, 4'd2);
        guess_step(16'h0100);
        guess_step(16'h0200);
        check("lose", {27'd0, lost, remaining}, {27'd0, 1'b1, 4'd0});

        // Start from LOSE clears level; invalid and repeat guesses
        start_round(16'h0013, 4'd3);
        check("level_cleared", 32'(level), 32'd0);
        guess_step(16'h0001);
        guess_step(16'h0003);
        guess_step(16'h0000);
        guess_step(16'h0001);
        check("repeat_pulse", 32'(repeat_g), 32'd1);
        guess_step(16'h0100);
        idle_step();

        // Reset mid-round
        step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0);
        check("mid_reset", {found, remaining, level}, 24'd0);

        // Zero budget behaves as one
        start_round(16'h0002, 4'd0);
        guess_step(16'h0001);
        check("budget0_lost", 32'(lost), 32'd1);

        // Start is ignored during SHOW and PLAY
        step(1'b1, 1'b1, 16'h0004, 4'd2, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h00F0, 4'd5, 1'b0, 16'h0);
        repeat (SHOW_N - 1) idle_step();
        step(1'b1, 1'b1, 16'h00F0, 4'd5, 1'b0, 16'h0);
        guess_step(16'h0004);
        // Start from WIN keeps level
        start_round(16'h0008, 4'd1);
        guess_step(16'h0008);
        check("level_kept", 32'(level), 32'd2);

        // Empty board wins on first PLAY cycle; level saturates
        for (int i = 0; i < 16; i++) begin
            start_round(16'h0000, 4'd1);
            idle_step();
        end
        check("level_sat", {27'd0, won, level}, {27'd0, 1'b1, 4'd15});

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 199) != 0);
            s   = ($urandom_range(0, 5) == 0);
            b   = 16'($urandom) & 16'($urandom) & 16'($urandom);
            bud = 4'($urandom_range(0, 5));
            v   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0, 1: begin tmp = m_tgt & ~m_fnd; g = tmp & (~tmp + 16'd1); end
                2:    g = 16'd1 << $urandom_range(0, 15);
                3:    g = 16'($urandom);
                default: begin tmp = m_fnd; g = tmp & (~tmp + 16'd1); end
            endcase
            step(r, s, b, bud, v, g);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
